// File: rtl/nf_gpio_pkg.sv
// Shared constants for the GPIO input conditioner: default widths and the pad-to-gpi latency offset.
// Pure declarations; no timing or flow control.
`ifndef NF_GPIO_WIDTH
`define NF_GPIO_WIDTH 8
`endif

package nf_gpio_pkg;

  localparam int NF_GPIO_DB_W = 16;

  // Two synchronizer stages plus the commit edge sit on top of the N debounce cycles.
  localparam int NF_GPIO_LAT_OFFSET = 3;

  function automatic int nf_gpio_latency(input int n);
    return n + NF_GPIO_LAT_OFFSET;
  endfunction

endpackage

// File: rtl/nf_gpio_db_bit.sv
// One GPIO bit: 2-flop synchronizer, debounce counter, stable value and edge pulses.
// Latency db_limit+3 edges from the sampling edge to stable; no backpressure, input sampled every cycle.
module nf_gpio_db_bit
  import nf_gpio_pkg::*;
#(
  parameter int db_w = NF_GPIO_DB_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            raw,
  input  logic [db_w-1:0] db_limit,
  output logic            stable,
  output logic            rise,
  output logic            fall
);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            stable_q, stable_d;
  logic [db_w-1:0] cnt_q, cnt_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= db_limit) begin
      // >= rather than == so a lowered limit commits at once and cnt never wraps.
      stable_d = s2_q;
      cnt_d    = '0;
      rise_d   = s2_q;
      fall_d   = ~s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/nf_gpio_in_cond.sv
// GPIO input conditioner: per-bit debounce and edge detect, plus sticky edge-interrupt flags ahead of the GPIO gpi port.
// gpi lags pads by db_limit+3 edges, irq_pend one edge after a pulse; no backpressure.
module nf_gpio_in_cond
  import nf_gpio_pkg::*;
#(
  parameter int gpio_w = `NF_GPIO_WIDTH,
  parameter int db_w   = NF_GPIO_DB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [gpio_w-1:0] gpi_raw,
  input  logic [db_w-1:0]   db_limit,
  input  logic [gpio_w-1:0] rise_en,
  input  logic [gpio_w-1:0] fall_en,
  input  logic [gpio_w-1:0] irq_clr,
  output logic [gpio_w-1:0] gpi,
  output logic [gpio_w-1:0] rise,
  output logic [gpio_w-1:0] fall,
  output logic [gpio_w-1:0] irq_pend,
  output logic              irq
);

  logic [gpio_w-1:0] irq_pend_q, irq_pend_d;

  for (genvar i = 0; i < gpio_w; i++) begin : g_bit
    nf_gpio_db_bit #(
      .db_w(db_w)
    ) u_db_bit (
      .clk     (clk),
      .reset   (reset),
      .raw     (gpi_raw[i]),
      .db_limit(db_limit),
      .stable  (gpi[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  // A new event wins over a coincident clear so it is never lost.
  always_comb begin
    irq_pend_d = (irq_pend_q & ~irq_clr) | (rise & rise_en) | (fall & fall_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pend_q <= '0;
    end else begin
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pend = irq_pend_q;
  assign irq      = |irq_pend_q;

endmodule

// File: tb/tb_nf_gpio_in_cond.sv
// Bench for nf_gpio_in_cond: directed latency/glitch/irq/reset scenarios plus random traffic against a cycle model.
module tb_nf_gpio_in_cond;
  import nf_gpio_pkg::*;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  gpi_raw, rise_en, fall_en, irq_clr;
  logic [15:0]   db_limit;
  logic [W-1:0]  gpi, rise, fall, irq_pend;
  logic          irq;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_s1, m_s2, m_stab, m_rise, m_fall, m_pend;
  int           m_run [W];

  always #5 clk = ~clk;

  nf_gpio_in_cond #(.gpio_w(W), .db_w(16)) dut (
    .clk(clk), .reset(reset), .gpi_raw(gpi_raw), .db_limit(db_limit),
    .rise_en(rise_en), .fall_en(fall_en), .irq_clr(irq_clr),
    .gpi(gpi), .rise(rise), .fall(fall), .irq_pend(irq_pend), .irq(irq)
  );

  // Advance one clock edge, update the model with the inputs seen at that edge, then settle.
  task automatic step();
    logic [W-1:0] nr, nf, ns;
    @(posedge clk);
    nr = '0;
    nf = '0;
    ns = m_stab;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_rise = '0; m_fall = '0; m_pend = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        // m_run = edges the synchronized input has already disagreed with the stable value
        if (m_s2[i] != m_stab[i]) begin
          if (m_run[i] >= int'(db_limit)) begin
            ns[i] = m_s2[i];
            nr[i] = m_s2[i];
            nf[i] = ~m_s2[i];
            m_run[i] = 0;
          end else begin
            m_run[i] = m_run[i] + 1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_pend = (m_pend & ~irq_clr) | (m_rise & rise_en) | (m_fall & fall_en);
      m_stab = ns;
      m_rise = nr;
      m_fall = nf;
      m_s2   = m_s1;
      m_s1   = gpi_raw;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if ({gpi, rise, fall, irq_pend, irq} !== 33'd0) begin
      failures++;
      $display("FAIL reset_state: got %h want 0", {gpi, rise, fall, irq_pend, irq});
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (gpi !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: gpi=%h irq=%b want 0/0", gpi, irq);
    end
  endtask

  task automatic test_latency_n4();
    db_limit = 16'd4;
    for (int k = 0; k < 4; k++) step();
    gpi_raw[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if ({gpi, rise, fall, irq_pend, irq} !== {m_stab, m_rise, m_fall, m_pend, |m_pend}) begin
        failures++;
        $display("FAIL lat4_model edge %0d: got %h want %h", k,
                 {gpi, rise, fall, irq_pend, irq}, {m_stab, m_rise, m_fall, m_pend, |m_pend});
      end
      checks++;
      if (gpi[0] !== (k >= nf_gpio_latency(4)) || rise[0] !== (k == 7) || fall[0] !== 1'b0) begin
        failures++;
        $display("FAIL lat4_edge edge %0d: gpi0=%b rise0=%b fall0=%b want %b/%b/0",
                 k, gpi[0], rise[0], fall[0], k >= 7, k == 7);
      end
    end
  endtask

  task automatic test_glitch();
    logic saw;
    db_limit = 16'd4;
    rise_en  = 8'h02;
    gpi_raw[1] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    gpi_raw[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (gpi[1] !== 1'b0 || rise[1] !== 1'b0 || irq_pend[1] !== 1'b0) begin
        failures++;
        $display("FAIL glitch3 step %0d: gpi1=%b rise1=%b pend1=%b want 0/0/0", k, gpi[1], rise[1], irq_pend[1]);
      end
    end
    saw = 1'b0;
    gpi_raw[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin step(); saw |= gpi[1]; end
    gpi_raw[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin step(); saw |= gpi[1]; end
    checks++;
    if (saw !== 1'b1 || irq_pend[1] !== 1'b1) begin
      failures++;
      $display("FAIL pulse5: saw_gpi1=%b pend1=%b want 1/1", saw, irq_pend[1]);
    end
    rise_en = 8'h00;
    irq_clr = 8'hff;
    step();
    irq_clr = 8'h00;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (gpi !== m_stab || irq_pend !== 8'h00) begin
      failures++;
      $display("FAIL glitch_settle: gpi=%h pend=%h want %h/00", gpi, irq_pend, m_stab);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] hist [64];
    int nrise, nfall;
    logic last_rise;
    db_limit = 16'd0;
    nrise = 0; nfall = 0; last_rise = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) gpi_raw[2] = ~gpi_raw[2];
      hist[k] = gpi_raw;
      step();
      if (k >= 3) begin
        checks++;
        if (gpi[2] !== hist[k-2][2]) begin
          failures++;
          $display("FAIL bypass_lag step %0d: gpi2=%b want %b", k, gpi[2], hist[k-2][2]);
        end
      end
      if (rise[2] === 1'b1 || fall[2] === 1'b1) begin
        checks++;
        if ((nrise + nfall > 0) && (rise[2] === last_rise)) begin
          failures++;
          $display("FAIL bypass_alt step %0d: repeated %s pulse", k, rise[2] ? "rise" : "fall");
        end
        last_rise = rise[2];
        if (rise[2]) nrise++; else nfall++;
      end
    end
    checks++;
    if (nrise < 4 || nfall < 4) begin
      failures++;
      $display("FAIL bypass_count: rise=%0d fall=%0d want >=4 each", nrise, nfall);
    end
  endtask

  task automatic test_irq();
    int n;
    db_limit = 16'd2;
    rise_en  = 8'h01;
    fall_en  = 8'h00;
    gpi_raw  = 8'h00;
    for (int k = 0; k < 10; k++) step();
    irq_clr = 8'hff;
    step();
    irq_clr = 8'h00;
    gpi_raw[0] = 1'b1;
    for (int k = 0; k < 10; k++) step();
    gpi_raw[0] = 1'b0;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (irq_pend !== 8'h01 || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_set: pend=%h irq=%b want 01/1", irq_pend, irq);
    end
    irq_clr = 8'h01;
    step();
    irq_clr = 8'h00;
    checks++;
    if (irq_pend !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clr: pend=%h irq=%b want 00/0", irq_pend, irq);
    end
    gpi_raw[0] = 1'b1;
    n = 0;
    while (rise[0] !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (rise[0] !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise_wait: no rise within 20 cycles");
    end
    irq_clr = 8'h01;
    step();
    irq_clr = 8'h00;
    checks++;
    if (irq_pend[0] !== 1'b1) begin
      failures++;
      $display("FAIL irq_set_wins: pend0=%b want 1", irq_pend[0]);
    end
    rise_en = 8'h00;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (irq_pend[0] !== 1'b1 || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_en_off_keeps: pend0=%b irq=%b want 1/1", irq_pend[0], irq);
    end
  endtask

  task automatic test_reset_mid();
    logic any_rise;
    db_limit = 16'd100;
    gpi_raw  = 8'h00;
    reset = 1'b1; step(); reset = 1'b0;
    gpi_raw[0] = 1'b1;
    for (int k = 0; k < 52; k++) step();
    reset = 1'b1;
    step();
    checks++;
    if ({gpi, rise, fall, irq_pend, irq} !== 33'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h want 0", {gpi, rise, fall, irq_pend, irq});
    end
    reset = 1'b0;
    any_rise = 1'b0;
    for (int k = 1; k <= 104; k++) begin
      step();
      if (k < 103) any_rise |= rise[0] | gpi[0];
      if (k == 103) begin
        checks++;
        if (gpi[0] !== 1'b1 || rise[0] !== 1'b1 || any_rise !== 1'b0) begin
          failures++;
          $display("FAIL reset_mid_latency: gpi0=%b rise0=%b early=%b want 1/1/0", gpi[0], rise[0], any_rise);
        end
      end
    end
  endtask

  task automatic test_lower_limit();
    db_limit = 16'd100;
    gpi_raw  = 8'h00;
    reset = 1'b1; step(); reset = 1'b0;
    gpi_raw[3] = 1'b1;
    for (int k = 0; k < 52; k++) step();
    checks++;
    if (gpi[3] !== 1'b0) begin
      failures++;
      $display("FAIL lower_pre: gpi3=%b want 0", gpi[3]);
    end
    db_limit = 16'd10;
    step();
    checks++;
    if (gpi[3] !== 1'b1 || rise[3] !== 1'b1) begin
      failures++;
      $display("FAIL lower_commit: gpi3=%b rise3=%b want 1/1", gpi[3], rise[3]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      if (k % 100 == 0) db_limit = 16'($urandom_range(0, 6));
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 3) == 0) gpi_raw[i] = ~gpi_raw[i];
      rise_en = 8'($urandom);
      fall_en = 8'($urandom);
      irq_clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step();
      checks++;
      if ({gpi, rise, fall, irq_pend, irq} !== {m_stab, m_rise, m_fall, m_pend, |m_pend}) begin
        failures++;
        $display("FAIL random step %0d: got %h want %h", k,
                 {gpi, rise, fall, irq_pend, irq}, {m_stab, m_rise, m_fall, m_pend, |m_pend});
      end
    end
  endtask

  initial begin
    reset = 1'b1; gpi_raw = '0; db_limit = 16'd4;
    rise_en = '0; fall_en = '0; irq_clr = '0;
    m_s1 = '0; m_s2 = '0; m_stab = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    test_reset();
    test_latency_n4();
    test_glitch();
    test_bypass();
    test_irq();
    test_reset_mid();
    test_lower_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nf_gpio_in_cond.md
NF_GPIO_IN_COND -- requirements
Module: nf_gpio_in_cond

Interface
REQ-001 Parameter gpio_w, default `NF_GPIO_WIDTH, number of GPIO input bits conditioned.
REQ-002 Parameter db_w, default 16, width of the debounce limit and per-bit counters.
REQ-003 Port clk input 1, single clock for all state.
REQ-004 Port reset input 1, reset: synchronous and active-high.
REQ-005 Port gpi_raw input gpio_w, asynchronous pad inputs.
REQ-006 Port db_limit input db_w, debounce length N; quasi-static configuration.
REQ-007 Port rise_en input gpio_w, per-bit rising-edge interrupt enable.
REQ-008 Port fall_en input gpio_w, per-bit falling-edge interrupt enable.
REQ-009 Port irq_clr input gpio_w, per-bit single-cycle clear of pending interrupt.
REQ-010 Port gpi output gpio_w, debounced stable value; feeds the GPIO unit's gpi input.
REQ-011 Port rise output gpio_w, one-cycle pulse on a debounced 0->1 change.
REQ-012 Port fall output gpio_w, one-cycle pulse on a debounced 1->0 change.
REQ-013 Port irq_pend output gpio_w, sticky per-bit pending flags.
REQ-014 Port irq output 1, OR-reduction of irq_pend.

Function
REQ-015 Each bit shall pass gpi_raw through a two-flop synchronizer (s1, s2) before any other use.
REQ-016 Each bit shall hold registers stable (drives gpi) and cnt (db_w bits).
REQ-017 Per cycle: if s2==stable then cnt<=0; else if cnt>=db_limit then stable<=s2, cnt<=0; else cnt<=cnt+1.
REQ-018 Latency from the first clock edge sampling a new gpi_raw level to gpi showing it shall be exactly N+3 cycles.
REQ-019 A level on s2 lasting N cycles or fewer shall not change gpi; cnt shall return to 0 once s2 equals stable again.
REQ-020 N=0 shall give bypass debounce: gpi follows s2 one cycle later (latency 3).
REQ-021 The >= compare shall ensure that lowering db_limit below a running cnt commits on the next cycle; cnt shall never wrap.
REQ-022 rise[i]/fall[i] shall be registered and high exactly in the first cycle gpi[i] shows its new value, for one cycle only.
REQ-023 irq_pend[i] shall set at the edge after (rise[i]&rise_en[i]) | (fall[i]&fall_en[i]).
REQ-024 irq_pend[i] shall clear at the edge after irq_clr[i]=1; a simultaneous set and clear shall leave it set.
REQ-025 Disabling rise_en/fall_en shall not clear already-pending flags.
REQ-026 irq shall be combinational OR of irq_pend, with no extra latency.
REQ-027 Bits shall be fully independent; simultaneous events on several bits shall all be captured.

Reset
REQ-028 While reset=1 at a clock edge, s1, s2, stable, cnt, rise, fall and irq_pend shall all load 0; gpi, irq = 0.
REQ-029 Reset asserted mid-debounce shall abort the count; no edge pulse or pending flag shall result.
REQ-030 After reset release, a pad held at 1 shall produce gpi=1 and one rise pulse after N+3 cycles.

Structure
REQ-031 Package nf_gpio_pkg shall hold the default db_w constant and the latency constant (3 + N formula offset).
REQ-032 Sub-module nf_gpio_db_bit shall implement synchronizer, counter, stable and edge pulses for one bit; the top generates gpio_w instances plus the irq_pend logic.
REQ-033 No bus interface; the top instantiates this block directly ahead of the AHB GPIO slave's gpi port.

Verification
REQ-034 N=4, gpi_raw[0] 0->1 held -> gpi[0]=1 exactly 7 cycles after the sampling edge; rise[0] high 1 cycle; fall stays 0.
REQ-035 N=4, 3-cycle high glitch on gpi_raw[1] -> gpi[1], rise[1], irq_pend[1] stay 0; a 5-cycle pulse does propagate.
REQ-036 N=0, toggle gpi_raw[2] every 4 cycles -> gpi[2] follows with 3-cycle lag; rise/fall pulses alternate.
REQ-037 rise_en=0x01, fall_en=0x00, bit0 rises then falls -> irq_pend=0x01, irq=1; irq_clr=0x01 -> irq_pend=0 next cycle; clear coincident with new rise -> stays 1.
REQ-038 N=100, reset pulsed at cnt=50 -> all outputs 0, no rise pulse; after release, full 103-cycle latency observed.
REQ-039 N=100, lower db_limit to 10 while cnt=50 -> gpi updates on the next cycle.
